// File: rtl/gpio_debounce_irq.sv
// gpio_debounce_irq: per-bit synchronizer, stability-counter debounce and sticky edge flags feeding one irq.
// Define GPIO_DEBOUNCE_IRQ_MASK_EN to add an irq_mask input that gates bits out of irq.
module gpio_debounce_irq #(
  parameter int Width          = 2,
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] gpio_in,
  output logic [Width-1:0] gpio_out,
  output logic [Width-1:0] rise_pending,
  output logic [Width-1:0] fall_pending,
  input  logic [Width-1:0] irq_clear,
`ifdef GPIO_DEBOUNCE_IRQ_MASK_EN
  input  logic [Width-1:0] irq_mask,
`endif
  output logic             irq
);

  localparam int CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  // Synchronizer chain packed as one shift register; stage 0 occupies the low Width bits.
  logic [SyncStages*Width-1:0] r_sync;
  logic [Width-1:0]            w_s;
  logic [Width-1:0]            w_stable;
  logic [Width-1:0]            w_rise;
  logic [Width-1:0]            w_fall;
  logic [Width-1:0]            w_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[(SyncStages-1)*Width-1:0], gpio_in};
    end
  end

  assign w_s = r_sync[SyncStages*Width-1 -: Width];

  for (genvar b = 0; b < Width; b++) begin : g_bit
    logic [CntW-1:0] r_cnt;
    logic            r_stable;
    logic            r_rise;
    logic            r_fall;
    logic            w_accept;

    assign w_accept = (w_s[b] != r_stable) && (r_cnt == CntMax);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
        r_rise   <= 1'b0;
        r_fall   <= 1'b0;
      end else begin
        if ((w_s[b] == r_stable) || w_accept) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_accept) begin
          r_stable <= w_s[b];
        end
        // A set on the same edge as a clear wins.
        r_rise <= (r_rise & ~irq_clear[b]) | (w_accept &  w_s[b]);
        r_fall <= (r_fall & ~irq_clear[b]) | (w_accept & ~w_s[b]);
      end
    end

    assign w_stable[b] = r_stable;
    assign w_rise[b]   = r_rise;
    assign w_fall[b]   = r_fall;
  end

  assign gpio_out     = w_stable;
  assign rise_pending = w_rise;
  assign fall_pending = w_fall;

`ifdef GPIO_DEBOUNCE_IRQ_MASK_EN
  assign w_pend = (w_rise | w_fall) & ~irq_mask;
`else
  assign w_pend = w_rise | w_fall;
`endif

  assign irq = |w_pend;

endmodule

// File: tb/tb_gpio_debounce_irq.sv
// Self-checking bench for gpio_debounce_irq: directed vector table, corner sequences, random vs window model.
module tb_gpio_debounce_irq;

  localparam int W  = 2;
  localparam int SS = 2;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] gpio_in = '0;
  logic [W-1:0] irq_clear = '0;
  logic [W-1:0] gpio_out, rise_pending, fall_pending;
  logic         irq;
`ifdef GPIO_DEBOUNCE_IRQ_MASK_EN
  logic [W-1:0] irq_mask = '0;
`endif

  int total = 0;
  int bad   = 0;

  gpio_debounce_irq #(.Width(W), .SyncStages(SS), .DebounceCycles(DC)) dut (
    .clk          (clk),
    .rst          (rst),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out),
    .rise_pending (rise_pending),
    .fall_pending (fall_pending),
    .irq_clear    (irq_clear),
`ifdef GPIO_DEBOUNCE_IRQ_MASK_EN
    .irq_mask     (irq_mask),
`endif
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // Reference model: s is the input sampled SS edges ago; a bit's stable level flips once the
  // last DC values of s all differ from it.
  logic [W-1:0] m_raw[$];
  logic [W-1:0] m_sh[$];
  logic [W-1:0] m_stable, m_rise, m_fall;

  task automatic model_reset();
    m_raw = {};
    m_sh  = {};
    for (int i = 0; i < SS; i++) m_raw.push_back('0);
    for (int i = 0; i < DC; i++) m_sh.push_back('0);
    m_stable = '0;
    m_rise   = '0;
    m_fall   = '0;
  endtask

  task automatic model_edge(input logic r, input logic [W-1:0] gin, input logic [W-1:0] clr);
    logic [W-1:0] s, set_r, set_f, nst;
    bit all_diff;
    if (r) begin
      model_reset();
    end else begin
      s = m_raw.pop_front();
      m_raw.push_back(gin);
      void'(m_sh.pop_front());
      m_sh.push_back(s);
      set_r = '0;
      set_f = '0;
      nst   = m_stable;
      for (int b = 0; b < W; b++) begin
        all_diff = 1;
        foreach (m_sh[j]) if (m_sh[j][b] == m_stable[b]) all_diff = 0;
        if (all_diff) begin
          nst[b] = s[b];
          if (s[b]) set_r[b] = 1'b1; else set_f[b] = 1'b1;
        end
      end
      m_stable = nst;
      m_rise   = (m_rise & ~clr) | set_r;
      m_fall   = (m_fall & ~clr) | set_f;
    end
  endtask

  function automatic logic model_irq();
`ifdef GPIO_DEBOUNCE_IRQ_MASK_EN
    return |((m_rise | m_fall) & ~irq_mask);
`else
    return |(m_rise | m_fall);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [W-1:0] gin, input logic [W-1:0] clr);
    rst       = r;
    gpio_in   = gin;
    irq_clear = clr;
    @(posedge clk);
    model_edge(r, gin, clr);
    #1;
  endtask

  typedef struct {
    logic         rst;
    logic [W-1:0] gin;
    logic [W-1:0] clr;
    logic [W-1:0] eo;
    logic [W-1:0] er;
    logic [W-1:0] ef;
    logic         ei;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [W-1:0] gin, input logic [W-1:0] clr,
                              input logic [W-1:0] eo, input logic [W-1:0] er,
                              input logic [W-1:0] ef, input logic ei);
    vec_t v;
    v.rst = r; v.gin = gin; v.clr = clr; v.eo = eo; v.er = er; v.ef = ef; v.ei = ei;
    tbl.push_back(v);
  endfunction

  initial begin
    model_reset();

    // Reset with inputs high, then rising on both bits at the 6th edge after release.
    for (int i = 0; i < 3; i++) add(1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    for (int i = 0; i < 5; i++) add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    add(0, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 1);
    // Clear, then fall both bits back to 0.
    add(0, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 0);
    for (int i = 0; i < 4; i++) add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 0);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1);
    add(0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 0);
    // 3-cycle glitch on bit 0 is rejected.
    for (int i = 0; i < 3; i++) add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    for (int i = 0; i < 6; i++) add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    // Bit 1 rises, is cleared, then falls and is cleared.
    for (int i = 0; i < 5; i++) add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    add(0, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 1);
    add(0, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 0);
    for (int i = 0; i < 5; i++) add(0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 0);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1);
    add(0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].gin, tbl[i].clr);
      chk($sformatf("tbl%0d_out", i),  gpio_out,     tbl[i].eo);
      chk($sformatf("tbl%0d_rise", i), rise_pending, tbl[i].er);
      chk($sformatf("tbl%0d_fall", i), fall_pending, tbl[i].ef);
      chk($sformatf("tbl%0d_irq", i),  irq,          tbl[i].ei);
    end

    // Set/clear collision: clear strobe lands on the edge that accepts the rise.
    for (int i = 0; i < 5; i++) step(0, 2'b01, 2'b00);
    chk("coll_pre_rise", rise_pending, 2'b00);
    chk("coll_pre_out", gpio_out, 2'b00);
    step(0, 2'b01, 2'b01);
    chk("coll_rise", rise_pending, 2'b01);
    chk("coll_out", gpio_out, 2'b01);
    chk("coll_irq", irq, 1);
    step(0, 2'b01, 2'b01);
    chk("coll_clear", rise_pending, 2'b00);

    // Reset mid-debounce discards the partial count; full latency restarts after release.
    for (int i = 0; i < 3; i++) step(1, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) step(0, 2'b01, 2'b00);
    step(1, 2'b01, 2'b00);
    chk("mid_rst_out", gpio_out, 2'b00);
    chk("mid_rst_rise", rise_pending, 2'b00);
    for (int i = 0; i < 5; i++) begin
      step(0, 2'b01, 2'b00);
      chk($sformatf("mid_wait%0d_out", i), gpio_out, 2'b00);
      chk($sformatf("mid_wait%0d_rise", i), rise_pending, 2'b00);
    end
    step(0, 2'b01, 2'b00);
    chk("mid_done_out", gpio_out, 2'b01);
    chk("mid_done_rise", rise_pending, 2'b01);
    chk("mid_done_fall", fall_pending, 2'b00);
    step(0, 2'b01, 2'b01);
    chk("mid_one_event", rise_pending, 2'b00);

`ifdef GPIO_DEBOUNCE_IRQ_MASK_EN
    for (int i = 0; i < 2; i++) step(1, 2'b00, 2'b00);
    irq_mask = 2'b01;
    for (int i = 0; i < 6; i++) step(0, 2'b01, 2'b00);
    chk("mask_rise", rise_pending, 2'b01);
    chk("mask_irq_off", irq, 0);
    irq_mask = 2'b00;
    #1;
    chk("mask_irq_on", irq, 1);
`endif

    // Random stimulus against the model; inputs change slowly enough that some levels settle.
    begin
      logic [W-1:0] g, c;
      logic r;
      g = gpio_in;
      for (int n = 0; n < 3000; n++) begin
        for (int b = 0; b < W; b++) if ($urandom_range(0, 5) == 0) g[b] = ~g[b];
        c = ($urandom_range(0, 9) == 0) ? W'($urandom) : '0;
        r = ($urandom_range(0, 299) == 0);
`ifdef GPIO_DEBOUNCE_IRQ_MASK_EN
        if ($urandom_range(0, 19) == 0) irq_mask = W'($urandom);
`endif
        step(r, g, c);
        chk("rnd_out",  gpio_out,     m_stable);
        chk("rnd_rise", rise_pending, m_rise);
        chk("rnd_fall", fall_pending, m_fall);
        chk("rnd_irq",  irq,          model_irq());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_debounce_irq.md
Name: gpio_debounce_irq

Overview:
- Per-bit GPIO conditioning stage between Renode-driven GPIO outputs and the HDL logic that consumes them.
- Synchronizes each bit, debounces it with a per-bit stability counter, and presents the clean level.
- Latches rising- and falling-edge events as sticky pending flags and raises a combined interrupt until software clears them.
- The `gpio_out` and `irq` outputs are fed back to Renode as GPIO inputs.

Parameters:
- Width, 2, number of GPIO bits handled (>=1).
- SyncStages, 2, synchronizer flops per bit (>=2).
- DebounceCycles, 4, consecutive cycles a new level must persist before acceptance (>=1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- gpio_in  input  Width  raw GPIO levels from Renode; asynchronous to clk.
- gpio_out  output  Width  debounced stable levels.
- rise_pending  output  Width  sticky rising-edge flags.
- fall_pending  output  Width  sticky falling-edge flags.
- irq_clear  input  Width  per-bit clear strobe; clears both rise and fall flags of that bit.
- irq  output  1  OR of all pending flags.

Behaviour:
- Reset:
  - Reset is synchronous and active-high: `rst` sampled high at a rising edge of `clk` resets the block.
  - On reset, clear all synchronizer flops, stable levels, counters, rise_pending and fall_pending to 0.
  - After reset, gpio_out=0 and irq=0 from the first edge.
  - Reset mid-debounce discards the partial count; no edge is recorded.
- Synchronizer:
  - sync[0] <= gpio_in; sync[i] <= sync[i-1].
  - s = sync[SyncStages-1].
- Debounce, per bit; counter width $clog2(DebounceCycles):
  - s == stable: cnt <= 0.
  - s != stable and cnt < DebounceCycles-1: cnt <= cnt+1.
  - s != stable and cnt == DebounceCycles-1: stable <= s; cnt <= 0; set rise_pending if s=1, else set fall_pending.
  - A glitch shorter than DebounceCycles cycles at s resets cnt and produces no gpio_out change and no event.
- Latency: a gpio_in change set up before edge k appears on gpio_out after edge k+SyncStages+DebounceCycles-1. With defaults, that is the 6th sampling edge.
- gpio_out = stable, registered.
- Pending flags:
  - Flags are sticky.
  - irq_clear[b] high at an edge clears both flags of bit b.
  - Set and clear on the same edge: set wins; the flag stays 1.
  - Multiple edges before a clear collapse into a single flag; no counting.
  - rise and fall may both be 1 at once.
- irq = |(rise_pending | fall_pending), combinational from registered flags. No additional latency beyond the flag register.
- Bits are fully independent; simultaneous events on different bits are all recorded.

Optional Feature:
- Macro: GPIO_DEBOUNCE_IRQ_MASK_EN.
- When defined:
  - Adds input port `irq_mask` (Width bits).
  - irq = |((rise_pending | fall_pending) & ~irq_mask).
  - Masked bits still latch pending flags; unmasking a bit with a pending flag asserts irq combinationally.
- When undefined:
  - No `irq_mask` port.
  - irq is the unmasked OR as above.

Test Plan:
- Reset and idle:
  - Hold rst for 3 cycles with gpio_in=2'b11, then release.
  - gpio_out=0 and irq=0 during reset.
  - gpio_out=2'b11 exactly 6 edges after the first non-reset sampling edge.
  - rise_pending=2'b11 and irq=1 at that point.
- Glitch rejection:
  - After gpio_out=0, pulse gpio_in[0]=1 for 3 cycles, then 0.
  - gpio_out stays 0; rise_pending stays 0; irq stays 0.
- Clean falling edge and clear:
  - With gpio_out[1]=1, drive gpio_in[1]=0.
  - gpio_out[1]=0 after 6 edges; fall_pending[1]=1.
  - Pulse irq_clear=2'b10 for 1 cycle: fall_pending[1]=0 and irq=0 on the next cycle.
- Set/clear collision:
  - Assert irq_clear[0] on the same edge that bit 0 debounces a rising edge.
  - rise_pending[0]=1 after that edge.
- Reset mid-debounce:
  - Change gpio_in[0] 0->1 and assert rst at edge k+4.
  - After reset release with gpio_in[0] still 1, the full 6-edge latency restarts.
  - Exactly one rise event is recorded.
- Mask (GPIO_DEBOUNCE_IRQ_MASK_EN defined):
  - Set irq_mask=2'b01 and produce a rise on bit 0: rise_pending[0]=1 and irq=0.
  - Set irq_mask=0: irq=1 in the same cycle.
